// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: debounces the mode key and the three function keys, steps the
// one-hot display mode on each mode-key press and locks out function keys across a change.
module watch_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       KEY3,
  input  logic       KEY0_raw,
  input  logic       KEY1_raw,
  input  logic       KEY2_raw,
  output logic [2:0] mux_mode,
  output logic       mode_changed,
  output logic       KEY0,
  output logic       KEY1,
  output logic       KEY2
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    MODE_CLK = 3'b001,
    MODE_SW  = 3'b010,
    MODE_ALM = 3'b100
  } mode_e;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          db3_prev_q;
  // Mode kept as raw bits rather than the enum type so a corrupted value can be decoded and recovered.
  logic [2:0]    mode_q, mode_d;
  logic          chg_q, chg_d;
  logic          lock_q, lock_d;
  logic [2:0]    key_q, key_d;
  logic          advance;

  assign raw = {KEY3, KEY2_raw, KEY1_raw, KEY0_raw};

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) db_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    mode_d  = mode_q;
    chg_d   = 1'b0;
    advance = db3_prev_q & ~db_q[3];
    case (mode_q)
      MODE_CLK: if (advance) begin mode_d = MODE_SW;  chg_d = 1'b1; end
      MODE_SW:  if (advance) begin mode_d = MODE_ALM; chg_d = 1'b1; end
      MODE_ALM: if (advance) begin mode_d = MODE_CLK; chg_d = 1'b1; end
      default:  mode_d = MODE_CLK;
    endcase

    lock_d = lock_q;
    if (chg_d)             lock_d = 1'b1;
    else if (&db_q[2:0])   lock_d = 1'b0;
    // Gating on the next lockout value suppresses keys on the very edge the mode changes.
    key_d = lock_d ? '1 : db_q[2:0];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      db_q       <= '1;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      db3_prev_q <= 1'b1;
      mode_q     <= MODE_CLK;
      chg_q      <= 1'b0;
      lock_q     <= 1'b0;
      key_q      <= '1;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      db3_prev_q <= db_q[3];
      mode_q     <= mode_d;
      chg_q      <= chg_d;
      lock_q     <= lock_d;
      key_q      <= key_d;
    end
  end

  assign mux_mode     = mode_q;
  assign mode_changed = chg_q;
  assign KEY0         = key_q[0];
  assign KEY1         = key_q[1];
  assign KEY2         = key_q[2];

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus a randomized run against a
// sliding-window reference model of the debounce, mode sequence and key lockout.
module tb_watch_mode_ctrl;
  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       KEY3 = 1'b1, KEY0_raw = 1'b1, KEY1_raw = 1'b1, KEY2_raw = 1'b1;
  logic [2:0] mux_mode;
  logic       mode_changed, KEY0, KEY1, KEY2;

  int vec = 0;
  int err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  watch_mode_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .KEY3        (KEY3),
    .KEY0_raw    (KEY0_raw),
    .KEY1_raw    (KEY1_raw),
    .KEY2_raw    (KEY2_raw),
    .mux_mode    (mux_mode),
    .mode_changed(mode_changed),
    .KEY0        (KEY0),
    .KEY1        (KEY1),
    .KEY2        (KEY2)
  );

  // Reference model: a key level is accepted once the last D synchronised samples all
  // disagree with the accepted level; mode is an index 0..2 stepped mod 3 on each press.
  bit       m_hist [4][$];
  bit [3:0] m_db;
  bit       m_db3_prev;
  int       m_idx;
  bit       m_chg, m_lock;
  bit [2:0] m_key;

  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        m_hist[k].delete();
        for (int j = 0; j < D + 3; j++) m_hist[k].push_back(1'b1);
      end
      m_db = '1; m_db3_prev = 1'b1; m_idx = 0;
      m_chg = 1'b0; m_lock = 1'b0; m_key = '1;
    end else begin
      bit [3:0] old_db;
      bit [3:0] rawv;
      bit       adv, settled;
      int       n;
      old_db = m_db;
      adv    = m_db3_prev && !old_db[3];
      m_chg  = adv;
      if (adv) m_idx = (m_idx + 1) % 3;
      if (adv)                m_lock = 1'b1;
      else if (&old_db[2:0])  m_lock = 1'b0;
      m_key = m_lock ? 3'b111 : old_db[2:0];
      rawv = {KEY3, KEY2_raw, KEY1_raw, KEY0_raw};
      for (int k = 0; k < 4; k++) begin
        m_hist[k].push_back(rawv[k]);
        void'(m_hist[k].pop_front());
        n = m_hist[k].size();
        settled = 1'b1;
        for (int i = 0; i < D; i++)
          if (m_hist[k][n - 3 - i] == old_db[k]) settled = 1'b0;
        if (settled) m_db[k] = ~old_db[k];
      end
      m_db3_prev = old_db[3];
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    KEY3 = 1'b1; KEY0_raw = 1'b1; KEY1_raw = 1'b1; KEY2_raw = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] got;
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    KEY3 = 1'b0; KEY0_raw = 1'b0; KEY1_raw = 1'b0; KEY2_raw = 1'b0;
    #1;
    got = {mux_mode, mode_changed, KEY2, KEY1, KEY0};
    vec++;
    if (got !== 7'b001_0_111) begin
      err++; $display("FAIL reset_async: got %b want %b", got, 7'b001_0_111);
    end
    repeat (3) tick();
    got = {mux_mode, mode_changed, KEY2, KEY1, KEY0};
    vec++;
    if (got !== 7'b001_0_111) begin
      err++; $display("FAIL reset_held: got %b want %b", got, 7'b001_0_111);
    end
    apply_reset();
  endtask

  task automatic test_idle();
    logic [6:0] got;
    apply_reset();
    for (int e = 0; e < 10; e++) begin
      tick();
      got = {mux_mode, mode_changed, KEY2, KEY1, KEY0};
      vec++;
      if (got !== 7'b001_0_111) begin
        err++; $display("FAIL idle[%0d]: got %b want %b", e, got, 7'b001_0_111);
      end
    end
  endtask

  task automatic test_key3_hold();
    logic [3:0] got, exp;
    apply_reset();
    KEY3 = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b010 : 3'b001, (e == 7)};
      got = {mux_mode, mode_changed};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL key3_hold edge %0d: got %b want %b", e, got, exp);
      end
    end
    KEY3 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      got = {mux_mode, mode_changed};
      vec++;
      if (got !== 4'b010_0) begin
        err++; $display("FAIL key3_release edge %0d: got %b want %b", e, got, 4'b010_0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] got, exp;
    logic [2:0] m;
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      KEY3 = 1'b0;
      repeat (7) tick();
      m = 3'b001 << ((p + 1) % 3);
      exp = {m, 1'b1};
      got = {mux_mode, mode_changed};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL wrap press %0d: got %b want %b", p, got, exp);
      end
      tick();
      exp = {m, 1'b0};
      got = {mux_mode, mode_changed};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL wrap pulse_end %0d: got %b want %b", p, got, exp);
      end
      KEY3 = 1'b1;
      repeat (8) tick();
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got;
    apply_reset();
    KEY3 = 1'b0;
    repeat (3) tick();
    KEY3 = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      got = {mux_mode, mode_changed};
      vec++;
      if (got !== 4'b001_0) begin
        err++; $display("FAIL glitch edge %0d: got %b want %b", e, got, 4'b001_0);
      end
    end
  endtask

  task automatic test_key_lockout();
    logic exp;
    apply_reset();
    KEY1_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6 || e == 8) begin
        exp = (e == 6);
        vec++;
        if (KEY1 !== exp) begin
          err++; $display("FAIL key1_press edge %0d: got %b want %b", e, KEY1, exp);
        end
      end
    end
    KEY3 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = (e >= 7);
      vec++;
      if (KEY1 !== exp) begin
        err++; $display("FAIL key1_lockout edge %0d: got %b want %b", e, KEY1, exp);
      end
    end
    vec++;
    if (mux_mode !== 3'b010) begin
      err++; $display("FAIL lockout_mode: got %b want %b", mux_mode, 3'b010);
    end
    KEY1_raw = 1'b1;
    KEY3 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      vec++;
      if (KEY1 !== 1'b1) begin
        err++; $display("FAIL key1_released edge %0d: got %b want 1", e, KEY1);
      end
    end
    KEY1_raw = 1'b0;
    repeat (8) tick();
    vec++;
    if (KEY1 !== 1'b0) begin
      err++; $display("FAIL key1_repress: got %b want 0", KEY1);
    end
    KEY1_raw = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    logic [6:0] got;
    logic [3:0] g4, exp;
    apply_reset();
    KEY3 = 1'b0;
    repeat (7) tick();
    KEY3 = 1'b1;
    repeat (8) tick();
    vec++;
    if (mux_mode !== 3'b010) begin
      err++; $display("FAIL reset_mid_setup: got %b want %b", mux_mode, 3'b010);
    end
    KEY3 = 1'b0;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    KEY3 = 1'b1;
    #1;
    got = {mux_mode, mode_changed, KEY2, KEY1, KEY0};
    vec++;
    if (got !== 7'b001_0_111) begin
      err++; $display("FAIL reset_mid_async: got %b want %b", got, 7'b001_0_111);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      g4 = {mux_mode, mode_changed};
      vec++;
      if (g4 !== 4'b001_0) begin
        err++; $display("FAIL reset_mid_idle edge %0d: got %b want %b", e, g4, 4'b001_0);
      end
    end
    KEY3 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 6) begin
        exp = {(e == 7) ? 3'b010 : 3'b001, (e == 7)};
        g4 = {mux_mode, mode_changed};
        vec++;
        if (g4 !== exp) begin
          err++; $display("FAIL reset_mid_repress edge %0d: got %b want %b", e, g4, exp);
        end
      end
    end
    KEY3 = 1'b1;
  endtask

  task automatic test_random();
    int         hold [4];
    logic [3:0] lvl;
    logic [2:0] em;
    logic [6:0] got, exp;
    apply_reset();
    lvl = '1;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          lvl[k]  = ($urandom_range(0, 2) == 0) ? 1'b1 : ~lvl[k];
          hold[k] = $urandom_range(1, 3 * D);
        end
        hold[k]--;
      end
      {KEY3, KEY2_raw, KEY1_raw, KEY0_raw} = lvl;
      tick();
      em  = 3'b001 << m_idx;
      exp = {em, m_chg, m_key};
      got = {mux_mode, mode_changed, KEY2, KEY1, KEY0};
      vec++;
      if (got !== exp) begin
        err++; $display("FAIL random cycle %0d: got %b want %b", c, got, exp);
      end
    end
    {KEY3, KEY2_raw, KEY1_raw, KEY0_raw} = '1;
  endtask

  task automatic test_illegal();
    apply_reset();
    @(negedge CLOCK_50);
    force dut.mode_q = 3'b011;
    @(posedge CLOCK_50);
    #1;
    release dut.mode_q;
    for (int e = 1; e <= 3; e++) begin
      tick();
      vec++;
      if (mux_mode !== 3'b001) begin
        err++; $display("FAIL illegal_recover edge %0d: got %b want %b", e, mux_mode, 3'b001);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_key3_hold();
    test_wrap();
    test_glitch();
    test_key_lockout();
    test_reset_mid();
    test_random();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
